// File: rtl/hall_call_arbiter.sv
// Hall call capture, lamp hold and round-robin offer to the car dispatcher.
// Define HALL_CALL_REQUEUE_EN to re-offer dispatched calls that time out.
module hall_call_arbiter #(
    parameter int NUM_FLOORS     = 8,
    parameter int FLOOR_W        = $clog2(NUM_FLOORS),
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_FLOORS-1:0]                request,
    input  logic [NUM_FLOORS-1:0]                request_direction_up_ndown,
    output logic [NUM_FLOORS-1:0]                ack,
    output logic [NUM_FLOORS-1:0]                lamp_up,
    output logic [NUM_FLOORS-1:0]                lamp_down,
    output logic                                 call_valid,
    output logic [FLOOR_W-1:0]                   call_floor,
    output logic                                 call_dir_up,
    input  logic                                 call_ready,
    input  logic                                 serviced_valid,
    input  logic [FLOOR_W-1:0]                   serviced_floor,
    input  logic                                 serviced_dir_up,
    output logic [$clog2(2*NUM_FLOORS+1)-1:0]    pending_count
);
    localparam int NC = 2 * NUM_FLOORS;
    localparam int IW = $clog2(NC);
    localparam int CW = $clog2(NC + 1);

    typedef enum logic {IDLE, OFFER} state_t;

    state_t                state_q, state_d;
    logic [NUM_FLOORS-1:0] req_q, ack_q, ack_d;
    logic [NC-1:0]         pend_q, pend_d, disp_q, disp_d;
    logic [NC-1:0]         cand, set_m, svc_m, acc_m, tmo_m;
    logic [IW-1:0]         rr_q, rr_d, pick, sel;
    logic                  found;
    logic [FLOOR_W-1:0]    floor_q, floor_d;
    logic                  dir_q, dir_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    // Candidate bit 2f is the up call at floor f, 2f+1 the down call.
    assign sel = {floor_q, ~dir_q};

    always_comb begin
        ack_d = '0;
        set_m = '0;
        svc_m = '0;
        for (int f = 0; f < NUM_FLOORS; f++) begin
            if (request[f] && !req_q[f]) begin
                if (request_direction_up_ndown[f] && f != NUM_FLOORS - 1) begin
                    ack_d[f]     = 1'b1;
                    set_m[2*f]   = 1'b1;
                end else if (!request_direction_up_ndown[f] && f != 0) begin
                    ack_d[f]     = 1'b1;
                    set_m[2*f+1] = 1'b1;
                end
            end
        end
        if (serviced_valid) begin
            svc_m[{serviced_floor, ~serviced_dir_up}] = 1'b1;
        end
    end

    // A call being serviced this cycle is never selected for an offer.
    assign cand = pend_q & ~disp_q & ~svc_m;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < NC; i++) begin
            if (!found && cand[(int'(rr_q) + i) % NC]) begin
                found = 1'b1;
                pick  = IW'((int'(rr_q) + i) % NC);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        floor_d = floor_q;
        dir_d   = dir_q;
        acc_m   = '0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = OFFER;
                    floor_d = pick[IW-1:1];
                    dir_d   = ~pick[0];
                end
            end
            OFFER: begin
                if (call_ready) begin
                    acc_m[sel] = 1'b1;
                    rr_d       = sel + 1'b1;
                    state_d    = IDLE;
                end else if (svc_m[sel]) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        pend_d = (pend_q | set_m) & ~svc_m;
        disp_d = (disp_q | acc_m) & ~svc_m & ~tmo_m;
        cnt_d  = '0;
        for (int i = 0; i < NC; i++) begin
            cnt_d = cnt_d + CW'(pend_d[i]);
        end
    end

`ifdef HALL_CALL_REQUEUE_EN
    localparam int AW = $clog2(TIMEOUT_CYCLES);

    logic [AW-1:0] age_q [NC];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NC; i++) age_q[i] <= '0;
        end else begin
            for (int i = 0; i < NC; i++) begin
                if (acc_m[i] || svc_m[i] || tmo_m[i]) begin
                    age_q[i] <= '0;
                end else if (disp_q[i]) begin
                    age_q[i] <= age_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        tmo_m = '0;
        for (int i = 0; i < NC; i++) begin
            tmo_m[i] = disp_q[i] && pend_q[i] &&
                       age_q[i] == AW'(TIMEOUT_CYCLES - 1);
        end
    end
`else
    // Dispatched calls stay dispatched until serviced.
    assign tmo_m = (TIMEOUT_CYCLES > 0) ? '0 : '0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            req_q   <= '0;
            ack_q   <= '0;
            pend_q  <= '0;
            disp_q  <= '0;
            rr_q    <= '0;
            floor_q <= '0;
            dir_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= request;
            ack_q   <= ack_d;
            pend_q  <= pend_d;
            disp_q  <= disp_d;
            rr_q    <= rr_d;
            floor_q <= floor_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        lamp_up   = '0;
        lamp_down = '0;
        for (int f = 0; f < NUM_FLOORS; f++) begin
            lamp_up[f]   = pend_q[2*f];
            lamp_down[f] = pend_q[2*f+1];
        end
    end

    assign ack           = ack_q;
    assign call_valid    = (state_q == OFFER);
    assign call_floor    = floor_q;
    assign call_dir_up   = dir_q;
    assign pending_count = cnt_q;
endmodule

// File: doc/hall_call_arbiter.md
Name: hall_call_arbiter

Overview:
- Building-controller front end directly downstream of the per-floor hall button panels.
- Captures each floor's request and direction, returns a one-cycle ack to the panel, and holds the call as pending with its lamp lit.
- Offers pending calls one at a time to the car dispatcher over a valid/ready handshake, using round-robin order.
- Clears a call when the dispatcher reports it serviced.

Parameters:
- NUM_FLOORS, 8, number of floors; floor 0 is the bottom floor, floor NUM_FLOORS-1 is the top floor.
- FLOOR_W, $clog2(NUM_FLOORS), width of floor indices.
- TIMEOUT_CYCLES, 1024, re-queue timeout; used only with HALL_CALL_REQUEUE_EN.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset; reset=0 clears all state.
- request  in  NUM_FLOORS  per-floor request from the hall panel; held high until acked.
- request_direction_up_ndown  in  NUM_FLOORS  per-floor direction; 1=up, 0=down.
- ack  out  NUM_FLOORS  per-floor one-cycle acknowledge back to the panel.
- lamp_up  out  NUM_FLOORS  up call pending.
- lamp_down  out  NUM_FLOORS  down call pending.
- call_valid  out  1  call offered to the dispatcher.
- call_floor  out  FLOOR_W  floor of the offered call.
- call_dir_up  out  1  direction of the offered call.
- call_ready  in  1  dispatcher accepts the offered call.
- serviced_valid  in  1  car has serviced a call this cycle.
- serviced_floor  in  FLOOR_W  floor of the serviced call.
- serviced_dir_up  in  1  direction of the serviced call.
- pending_count  out  $clog2(2*NUM_FLOORS+1)  number of pending calls.

Behaviour:
- Reset (reset=0, asynchronous): all pending, dispatched and ack registers clear; call_valid=0; call_floor=0; call_dir_up=0; pending_count=0; round-robin pointer=0; FSM=IDLE. Reset mid-offer withdraws the call immediately.
- Capture:
  - Rising-edge detect on request[f] using a registered copy of request.
  - An edge sampled at edge N sets pend_up[f] or pend_dn[f] per the direction bit.
  - ack[f]=1 during cycle N+1 only.
  - A held request never re-captures.
- Duplicate call (same floor and direction already pending): ack is still issued; state is unchanged.
- Illegal direction (up at top floor, down at floor 0): ignored; no ack; no pending bit set.
- lamp_up=pend_up and lamp_down=pend_dn, both registered.
- Candidate vector: 2*NUM_FLOORS bits; bit 2f = up call at floor f, bit 2f+1 = down call at floor f. A bit is a candidate when pending and not dispatched.
- FSM:
  - IDLE: if any candidate exists, select the first set bit at or after rr_ptr, cyclically; load call_floor and call_dir_up; go to OFFER. call_valid=1 from the next cycle.
  - OFFER: call_valid, call_floor and call_dir_up are held stable until call_ready=1. On call_valid&call_ready: set the dispatched bit; rr_ptr = selected index + 1 (mod 2*NUM_FLOORS); go to IDLE.
  - Maximum throughput is one call per 2 cycles.
- Service: serviced_valid clears the matching pending and dispatched bits at the next edge; the lamp goes off in the same cycle those bits clear. Service of a non-pending call is a no-op.
- Service of the offered call while in OFFER: call_valid drops next cycle; FSM goes to IDLE; no handshake occurs.
- Service and new request edge for the same floor and direction in the same cycle: service wins; the request is acked but not queued, because the car is at the floor.
- Acceptance and service of the same call in the same cycle: the call ends cleared.
- pending_count = popcount(pend_up | pend_dn as a 2N vector), registered, consistent with the lamps in the same cycle.

Optional Feature:
- Macro: HALL_CALL_REQUEUE_EN.
- Defined:
  - Each dispatched call has an age counter that starts at 0 on acceptance and increments every cycle.
  - When the counter reaches TIMEOUT_CYCLES-1 with the call still pending, the dispatched bit clears and the call becomes a candidate again.
  - Service clears the counter.
- Undefined: no counters are instantiated; a dispatched call stays dispatched until serviced.

Test Plan:
- Reset then request[3]=1, direction=1 held 5 cycles -> ack[3] high for exactly 1 cycle (cycle after edge); lamp_up[3]=1; pending_count=1; call_valid=1 with call_floor=3, call_dir_up=1.
- request[7] up (NUM_FLOORS=8) and request[0] down -> no ack; lamps stay 0; pending_count=0.
- Pending calls at floors 2u, 5d, 6u with call_ready=1 continuously -> offers in order 2u, 5d, 6u, each call_valid spaced 2 cycles apart; a later 1u is offered after wrap-around.
- call_ready=0 for 10 cycles with call 4d offered -> call_valid, call_floor=4, call_dir_up=0 stable; serviced_valid for 4d -> call_valid=0 next cycle; lamp_down[4]=0; pending_count decrements.
- reset pulled low while in OFFER with 3 calls pending -> all lamps, ack and call_valid are 0 immediately; pending_count=0.
- With HALL_CALL_REQUEUE_EN, TIMEOUT_CYCLES=16: accept 2u, never service -> 2u re-offered with call_valid after 16 cycles; without the macro, never re-offered.
